spi_receive_multi: RTL and testbench

Parametrised SPI-style pixel receiver. It samples a LINES-bit-wide data bus on rising edges of an externally driven DCLK while chip select is low, and assembles PIXEL_WIDTH-bit pixels from PIXEL_WIDTH/LINES beats. Completed pixels and their end-of-frame marker go into a small first-word-fall-through FIFO with a valid/ready output. It sits between the camera-link pins and the depth-mapping frame buffer writer, and adds backpressure, overrun detection and clean handling of aborted transfers.

---
 rtl/spi_rx_pkg.sv | 26 ++
 rtl/spi_rx_fifo.sv | 56 +++++
 rtl/spi_receive_multi.sv | 176 +++++++++++++++++
 tb/tb_spi_receive_multi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI pixel receiver: beat arithmetic, parameter legality and FIFO entry layout.
package spi_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_rx_state_t;

    localparam int SPI_RX_DEFAULT_PIXEL_WIDTH = 8;

    // Entry layout for the default pixel width; the top builds the same layout at its own width.
    typedef struct packed {
        logic [SPI_RX_DEFAULT_PIXEL_WIDTH-1:0] pixel;
        logic                                  last;
    } spi_rx_entry_t;

    function automatic int spi_rx_beats(input int pixel_width, input int lines);
        return pixel_width / lines;
    endfunction

    function automatic bit spi_rx_params_ok(input int lines, input int pixel_width, input int depth);
        return (lines >= 1) && (pixel_width >= lines) && ((pixel_width % lines) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module spi_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_receive_multi.sv
// SPI-style pixel receiver: assembles LINES-wide beats into pixels and queues them in a FWFT FIFO.
// Define SPI_RX_SYNC_EN to put 2-FF synchronizers on every chip-side input.
module spi_receive_multi
    import spi_rx_pkg::*;
#(
    parameter int LINES       = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [LINES-1:0]       chip_data_in,
    input  logic                   chip_clk_in,
    input  logic                   chip_sel_in,
    input  logic                   final_pixel_in,
    output logic [PIXEL_WIDTH-1:0] data_out,
    output logic                   last_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   overrun_out,
    output logic                   abort_out
);
    localparam bit PARAMS_OK = spi_rx_params_ok(LINES, PIXEL_WIDTH, FIFO_DEPTH);
    localparam int BEATS     = PARAMS_OK ? spi_rx_beats(PIXEL_WIDTH, LINES) : 1;
    localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] pixel;
        logic                   last;
    } entry_t;

    logic [LINES-1:0]       data_s;
    logic                   dclk_s;
    logic                   cs_n_s;
    logic                   fin_s;
    spi_rx_state_t          state_r;
    logic                   prev_clk_r;
    logic [CW-1:0]          beat_r;
    logic [CW-1:0]          beat_next_s;
    logic                   abort_r;
    logic                   overrun_r;
    logic                   rise_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [PIXEL_WIDTH-1:0] next_pixel_s;
    entry_t                 wr_entry_s;
    entry_t                 head_s;

`ifdef SPI_RX_SYNC_EN
    logic [1:0]       dclk_sync_r;
    logic [1:0]       cs_sync_r;
    logic [1:0]       fin_sync_r;
    logic [LINES-1:0] data_sync1_r;
    logic [LINES-1:0] data_sync2_r;

    // Two-stage synchronizers; CS resets to its inactive (high) level.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dclk_sync_r  <= 2'b00;
            cs_sync_r    <= 2'b11;
            fin_sync_r   <= 2'b00;
            data_sync1_r <= {LINES{1'b0}};
            data_sync2_r <= {LINES{1'b0}};
        end else begin
            dclk_sync_r  <= {dclk_sync_r[0], chip_clk_in};
            cs_sync_r    <= {cs_sync_r[0], chip_sel_in};
            fin_sync_r   <= {fin_sync_r[0], final_pixel_in};
            data_sync1_r <= chip_data_in;
            data_sync2_r <= data_sync1_r;
        end
    end

    assign dclk_s = dclk_sync_r[1];
    assign cs_n_s = cs_sync_r[1];
    assign fin_s  = fin_sync_r[1];
    assign data_s = data_sync2_r;
`else
    assign dclk_s = chip_clk_in;
    assign cs_n_s = chip_sel_in;
    assign fin_s  = final_pixel_in;
    assign data_s = chip_data_in;
`endif

    // prev_clk_r follows DCLK even with CS high, so a CS fall during DCLK high is not an edge.
    assign rise_s      = ~cs_n_s & ~prev_clk_r & dclk_s;
    assign beat_next_s = (beat_r == LAST_BEAT) ? {CW{1'b0}} : beat_r + CW'(1);
    assign push_s      = rise_s & (beat_r == LAST_BEAT);
    assign pop_s       = ~fifo_empty_s & ready_in;

    generate
        if (BEATS > 1) begin : g_shift
            logic [PIXEL_WIDTH-LINES-1:0] shift_r;

            // Earlier beats of the current pixel, first beat towards the MSBs.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    shift_r <= {(PIXEL_WIDTH - LINES){1'b0}};
                end else if (rise_s) begin
                    shift_r <= next_pixel_s[PIXEL_WIDTH-LINES-1:0];
                end else begin
                    shift_r <= shift_r;
                end
            end

            assign next_pixel_s = {shift_r, data_s};
        end else begin : g_no_shift
            assign next_pixel_s = data_s;
        end
    endgenerate

    // CS state machine, beat counter, abort pulse and sticky overrun flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            prev_clk_r <= 1'b0;
            beat_r     <= {CW{1'b0}};
            abort_r    <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            prev_clk_r <= dclk_s;
            abort_r    <= 1'b0;
            if (push_s && fifo_full_s && !pop_s) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (!cs_n_s) begin
                        state_r <= RECV;
                        beat_r  <= rise_s ? beat_next_s : {CW{1'b0}};
                    end else begin
                        beat_r <= {CW{1'b0}};
                    end
                end
                RECV: begin
                    if (cs_n_s) begin
                        state_r <= IDLE;
                        beat_r  <= {CW{1'b0}};
                        abort_r <= (beat_r != {CW{1'b0}});
                    end else if (rise_s) begin
                        beat_r <= beat_next_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign wr_entry_s = '{pixel: next_pixel_s, last: fin_s};

    spi_rx_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (push_s),
        .wr_data (wr_entry_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign data_out    = head_s.pixel;
    assign last_out    = head_s.last;
    assign valid_out   = ~fifo_empty_s;
    assign overrun_out = overrun_r;
    assign abort_out   = abort_r;

endmodule

// File: tb/tb_spi_receive_multi.sv
// Scoreboard bench for spi_receive_multi: a 4-line and a 2-line instance, directed pixel vectors.
module tb_spi_receive_multi;

`ifdef SPI_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_in;
    logic [3:0] a_data;
    logic       a_dclk, a_cs, a_fin, a_ready;
    logic [7:0] a_dout;
    logic       a_last, a_valid, a_overrun, a_abort;
    logic [1:0] b_data;
    logic       b_dclk, b_cs, b_fin, b_ready;
    logic [7:0] b_dout;
    logic       b_last, b_valid, b_overrun, b_abort;

    int checks = 0;
    int errors = 0;
    int abort_cnt = 0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] exp_a, exp_b;

    spi_receive_multi #(.LINES(4), .PIXEL_WIDTH(8), .FIFO_DEPTH(4)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .chip_data_in(a_data), .chip_clk_in(a_dclk),
        .chip_sel_in(a_cs), .final_pixel_in(a_fin), .data_out(a_dout), .last_out(a_last),
        .valid_out(a_valid), .ready_in(a_ready), .overrun_out(a_overrun), .abort_out(a_abort)
    );

    spi_receive_multi #(.LINES(2), .PIXEL_WIDTH(8), .FIFO_DEPTH(4)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .chip_data_in(b_data), .chip_clk_in(b_dclk),
        .chip_sel_in(b_cs), .final_pixel_in(b_fin), .data_out(b_dout), .last_out(b_last),
        .valid_out(b_valid), .ready_in(b_ready), .overrun_out(b_overrun), .abort_out(b_abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output beat is compared with the head of its scoreboard queue.
    always @(negedge clk_in) begin
        if (a_abort) abort_cnt++;
        if (a_valid && a_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got 0x%0h expected nothing", {a_last, a_dout});
            end else begin
                exp_a = qa.pop_front();
                check("a_pixel", {23'd0, a_last, a_dout}, {23'd0, exp_a});
            end
        end
        if (b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got 0x%0h expected nothing", {b_last, b_dout});
            end else begin
                exp_b = qb.pop_front();
                check("b_pixel", {23'd0, b_last, b_dout}, {23'd0, exp_b});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic beat_a(input logic [3:0] d, input logic fin);
        a_data = d; a_fin = fin; a_dclk = 1'b0;
        tick(2);
        a_dclk = 1'b1;
        tick(2);
    endtask

    task automatic beat_b(input logic [1:0] d, input logic fin);
        b_data = d; b_fin = fin; b_dclk = 1'b0;
        tick(2);
        b_dclk = 1'b1;
        tick(2);
    endtask

    task automatic pixel_a(input logic [7:0] pix, input logic fin, input logic expect_it);
        if (expect_it) qa.push_back({fin, pix});
        beat_a(pix[7:4], 1'b0);
        beat_a(pix[3:0], fin);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (a_valid && n < 50) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, a_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        qa.delete();
        qb.delete();
        tick(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;
        int snap;
        rst_in = 1'b1;
        a_data = 4'h0; a_dclk = 1'b0; a_cs = 1'b1; a_fin = 1'b0; a_ready = 1'b1;
        b_data = 2'h0; b_dclk = 1'b0; b_cs = 1'b1; b_fin = 1'b0; b_ready = 1'b1;
        tick(3);
        check("rst_data",    {24'd0, a_dout},    32'd0);
        check("rst_last",    {31'd0, a_last},    32'd0);
        check("rst_valid",   {31'd0, a_valid},   32'd0);
        check("rst_overrun", {31'd0, a_overrun}, 32'd0);
        check("rst_abort",   {31'd0, a_abort},   32'd0);
        rst_in = 1'b0;
        tick(2);

        // 0xA then 0x5: pixel 0xA5 visible LAT cycles after the final edge, for one cycle.
        a_cs = 1'b0;
        tick(2);
        beat_a(4'hA, 1'b0);
        qa.push_back(9'h0A5);
        a_data = 4'h5; a_fin = 1'b0; a_dclk = 1'b0;
        tick(2);
        a_dclk = 1'b1;
        for (int t = 1; t <= LAT + 1; t++) begin
            tick(1);
            check($sformatf("a5_valid_t%0d", t), {31'd0, a_valid}, (t == LAT) ? 32'd1 : 32'd0);
        end
        tick(2);

        // Two lines: beats 3,0,2,1 give 0xC9 with end-of-frame.
        b_cs = 1'b0;
        tick(2);
        qb.push_back(9'h1C9);
        beat_b(2'd3, 1'b0);
        beat_b(2'd0, 1'b0);
        beat_b(2'd2, 1'b0);
        beat_b(2'd1, 1'b1);
        tick(LAT + 3);
        b_cs = 1'b1;
        check("b_drained", qb.size(), 32'd0);

        // One beat then CS high: single abort pulse LAT cycles later, then a clean pixel.
        beat_a(4'h7, 1'b0);
        snap = abort_cnt;
        first = 0;
        a_cs = 1'b1;
        for (int t = 1; t <= LAT + 3; t++) begin
            tick(1);
            if (a_abort && first == 0) first = t;
        end
        check("abort_latency", first, LAT);
        check("abort_pulses", abort_cnt - snap, 32'd1);
        a_cs = 1'b0;
        tick(2);
        pixel_a(8'h3C, 1'b0, 1'b1);
        tick(LAT + 2);
        snap = abort_cnt;
        a_cs = 1'b1;
        tick(LAT + 4);
        check("no_abort_on_boundary", abort_cnt - snap, 32'd0);

        // CS falls while DCLK is already high: no beat until a genuine rising edge.
        a_dclk = 1'b1; a_data = 4'hF;
        tick(4);
        a_cs = 1'b0;
        tick(4);
        pixel_a(8'hD2, 1'b0, 1'b1);
        tick(LAT + 2);
        check("a_drained_1", qa.size(), 32'd0);

        // Stalled consumer: four pixels kept in order, fifth dropped, sticky overrun.
        a_ready = 1'b0;
        pixel_a(8'h11, 1'b0, 1'b1);
        pixel_a(8'h22, 1'b0, 1'b1);
        pixel_a(8'h33, 1'b0, 1'b1);
        pixel_a(8'h44, 1'b1, 1'b1);
        tick(LAT + 1);
        check("overrun_at_full", {31'd0, a_overrun}, 32'd0);
        pixel_a(8'h55, 1'b0, 1'b0);
        tick(LAT + 1);
        check("overrun_set",  {31'd0, a_overrun}, 32'd1);
        check("head_kept",    {24'd0, a_dout},    32'h11);
        a_ready = 1'b1;
        wait_drain("drain_overrun");
        check("a_drained_2",    qa.size(),          32'd0);
        check("overrun_sticky", {31'd0, a_overrun}, 32'd1);
        do_reset();
        check("overrun_cleared", {31'd0, a_overrun}, 32'd0);
        rst_in = 1'b0;
        tick(2);

        // Reset mid-pixel with a held entry: every output returns to zero.
        a_ready = 1'b0;
        tick(2);
        pixel_a(8'h96, 1'b1, 1'b1);
        beat_a(4'hE, 1'b0);
        tick(LAT);
        check("pre_rst_valid", {31'd0, a_valid}, 32'd1);
        a_dclk = 1'b0;
        do_reset();
        check("mid_rst_data",    {24'd0, a_dout},    32'd0);
        check("mid_rst_last",    {31'd0, a_last},    32'd0);
        check("mid_rst_valid",   {31'd0, a_valid},   32'd0);
        check("mid_rst_overrun", {31'd0, a_overrun}, 32'd0);
        check("mid_rst_abort",   {31'd0, a_abort},   32'd0);
        rst_in = 1'b0;
        a_ready = 1'b1;
        tick(3);
        pixel_a(8'h69, 1'b0, 1'b1);
        tick(LAT + 2);
        check("a_drained_3", qa.size(), 32'd0);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        a_ready = 1'b0;
        pixel_a(8'hA1, 1'b0, 1'b1);
        pixel_a(8'hB2, 1'b0, 1'b1);
        pixel_a(8'hC3, 1'b0, 1'b1);
        pixel_a(8'hD4, 1'b0, 1'b1);
        tick(LAT + 1);
        qa.push_back(9'h0E5);
        beat_a(4'hE, 1'b0);
        a_data = 4'h5; a_fin = 1'b0; a_dclk = 1'b0;
        tick(2);
        a_dclk = 1'b1;
        if (LAT > 1) tick(LAT - 1);
        a_ready = 1'b1;
        tick(2);
        check("overrun_push_pop", {31'd0, a_overrun}, 32'd0);
        wait_drain("drain_push_pop");
        check("a_drained_4", qa.size(), 32'd0);
        a_cs = 1'b1;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
